lc4_seq_alu: RTL and testbench
==============================

# lc4_seq_alu

Multi-cycle, width-parametrised arithmetic unit that sits beside the combinational LC4 ALU in the execute stage. It adds a persistent carry/borrow register for multi-word add, subtract and shift chains. It also adds iterative unsigned multiply and divide that take one result bit per cycle. The pipeline stalls on `o_ready` low and takes results on the single-cycle `o_done` pulse.

## Interface
- `WORD_SIZE`, default 16: operand/result width; any value ≥ 4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  operation request; accepted only when `o_ready` = 1.
- `i_op`  in  3  opcode, sampled at acceptance.
- `i_a`  in  WORD_SIZE  operand A, sampled at acceptance.
- `i_b`  in  WORD_SIZE  operand B, sampled at acceptance.
- `o_ready`  out  1  unit can accept a request this cycle.
- `o_done`  out  1  one-cycle pulse; results valid and held until the next acceptance.
- `o_result`  out  WORD_SIZE  low word, quotient, or sum/difference/shift result.
- `o_result_hi`  out  WORD_SIZE  product high word or remainder; 0 for other ops.
- `o_carry`  out  1  current carry/borrow register.
- `o_dz`  out  1  last DIV had B = 0; cleared at next acceptance.
- `o_err`  out  1  last op was reserved opcode 111; cleared at next acceptance.

## Operation
- Opcodes:
  - 000 ADDC: {c, r} = A + B + carry.
  - 001 SUBB: r = A − B − carry; carry ← borrow out.
  - 010 MUL: unsigned 2W-bit product.
  - 011 DIV: unsigned restoring divide.
  - 100 SHR1C: r = {carry, A[W-1:1]}; carry ← A[0].
  - 101 CLRC: carry ← 0.
  - 110 SETC: carry ← 1.
  - 111 reserved: r = 0, o_err = 1.
- CLRC and SETC leave `o_result` and `o_result_hi` at 0. Only ADDC, SUBB, SHR1C, CLRC and SETC modify carry.
- FSM states:
  - IDLE: `o_ready` = 1.
  - BUSY: `o_ready` = 0; iterative ops only.
  - DONE: `o_ready` = 1, `o_done` = 1.
- FSM transitions:
  - IDLE or DONE, with i_valid, single-cycle op → DONE.
  - IDLE or DONE, with i_valid, MUL/DIV → BUSY; load operands, count ← WORD_SIZE.
  - IDLE or DONE, without i_valid → IDLE.
  - BUSY, count > 1 → BUSY, count − 1.
  - BUSY, count = 1 → DONE.
- Back-to-back ops: a request in DONE is accepted; `o_done` for the new op follows per its latency.
- MUL: shift-add on a 2W-bit accumulator, one multiplier bit per BUSY cycle, LSB first.
- DIV: one quotient bit per BUSY cycle, MSB first, using a W+1-bit partial remainder.
  - B = 0 is not special-cased in the datapath. It yields quotient all ones and remainder = A, and sets `o_dz`.
- Counter width: $clog2(WORD_SIZE)+1.
- `i_valid` while `o_ready` = 0 is ignored, not queued.
- Input changes after acceptance have no effect.
- Reset values: `o_result` 0, `o_result_hi` 0, `o_carry` 0, `o_done` 0, `o_dz` 0, `o_err` 0, state IDLE, `o_ready` 1.
- `rst` during BUSY aborts the operation: no `o_done`, carry cleared, IDLE next cycle.
- `rst` takes priority over a simultaneous `i_valid`.

## Timing
- Acceptance cycle T is an edge where `i_valid` and `o_ready` are both 1.
- Single-cycle ops: `o_done` high in cycle T+1; results and carry update on the same edge.
- MUL/DIV: `o_ready` low in cycles T+1..T+WORD_SIZE; `o_done` high in cycle T+WORD_SIZE+1.
- For WORD_SIZE 16, the `o_done` cycle is T+17.
- Outputs are registered; `o_ready` decodes from state only, with no combinational path from `i_valid`.
- Throughput:
  - 1 op/cycle for single-cycle ops.
  - 1 op per WORD_SIZE+1 cycles for MUL/DIV.

## Test plan
- ADDC carry chain: CLRC, then ADDC A=FFFF B=0001, then ADDC A=0000 B=0000 (W=16).
  - First ADDC: r = 0000, carry 1, done at T+1.
  - Second ADDC: r = 0001, carry 0.
- MUL A=1234 B=5678 → o_result_hi = 0626, o_result = 0060, done at T+17, o_ready low T+1..T+16. Also MUL FFFF×FFFF → FFFE/0001.
- DIV A=FFFF B=0007 → o_result = 2492, o_result_hi = 0001.
- DIV by zero: A=1234 B=0000 → o_result = FFFF, o_result_hi = 1234, o_dz = 1. The next ADDC clears o_dz.
- SHR1C after SETC, A=0003 → o_result = 8001, carry 1. Then SUBB 0005−0003 → 0001, carry 0.
- Abort and ignore:
  - rst at T+5 of a MUL → o_ready 1 at T+6, no o_done, carry 0.
  - i_valid during BUSY is ignored.
  - Opcode 111 → o_result 0, o_err 1.
  - Rerun with WORD_SIZE=8 and 32.

Source files
------------

// File: rtl/lc4_seq_alu.sv
// Multi-cycle companion to the LC4 ALU: persistent carry for multi-word chains
// plus iterative unsigned multiply/divide producing one result bit per cycle.
module lc4_seq_alu #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [2:0]           i_op,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic                 o_ready,
  output logic                 o_done,
  output logic [WORD_SIZE-1:0] o_result,
  output logic [WORD_SIZE-1:0] o_result_hi,
  output logic                 o_carry,
  output logic                 o_dz,
  output logic                 o_err,
  output logic [1:0]           dbg_state
);
  // Handshake: a request is taken on any rising edge where i_valid and o_ready
  // are both 1; o_done pulses for one cycle when results and flags are valid.
  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_ADDC  = 3'b000;
  localparam logic [2:0] OP_SUBB  = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_SHR1C = 3'b100;
  localparam logic [2:0] OP_CLRC  = 3'b101;
  localparam logic [2:0] OP_SETC  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, next_state;
  logic           accept, is_iter, last_step;
  logic           op_mul;
  logic [W-1:0]   work_hi, work_lo, opnd_b;
  logic [CW-1:0]  count;

  logic [W:0]     add_sum, sub_diff, mul_sum, div_shift, div_diff;
  logic           div_ok;
  logic [W-1:0]   step_hi, step_lo;

  assign accept    = i_valid && (state != S_BUSY);
  assign is_iter   = (i_op == OP_MUL) || (i_op == OP_DIV);
  assign last_step = (count == CW'(1));
  assign o_ready   = (state != S_BUSY);
  assign o_done    = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) next_state = is_iter ? S_BUSY : S_DONE;
        else        next_state = S_IDLE;
      end
      S_BUSY:  if (last_step) next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  assign add_sum  = {1'b0, i_a} + {1'b0, i_b} + (W+1)'(o_carry);
  assign sub_diff = {1'b0, i_a} - {1'b0, i_b} - (W+1)'(o_carry);

  // Multiply: {work_hi, work_lo} is the 2W accumulator; multiplier bits leave work_lo LSB first.
  assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_b} : '0);

  // Divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
  // The remainder stays below B, so the W+1-bit difference sign is a true borrow.
  assign div_shift = {work_hi, work_lo[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_b};
  assign div_ok    = !div_diff[W];

  always_comb begin
    if (op_mul) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], work_lo[W-1:1]};
    end else begin
      step_hi = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
      step_lo = {work_lo[W-2:0], div_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_result    <= '0;
      o_result_hi <= '0;
      o_carry     <= 1'b0;
      o_dz        <= 1'b0;
      o_err       <= 1'b0;
      op_mul      <= 1'b0;
      work_hi     <= '0;
      work_lo     <= '0;
      opnd_b      <= '0;
      count       <= '0;
    end else if (state == S_BUSY) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
      count   <= count - CW'(1);
      if (last_step) begin
        o_result    <= step_lo;
        o_result_hi <= step_hi;
      end
    end else if (accept) begin
      o_dz  <= 1'b0;
      o_err <= 1'b0;
      case (i_op)
        OP_ADDC: begin
          o_result    <= add_sum[W-1:0];
          o_result_hi <= '0;
          o_carry     <= add_sum[W];
        end
        OP_SUBB: begin
          o_result    <= sub_diff[W-1:0];
          o_result_hi <= '0;
          o_carry     <= sub_diff[W];
        end
        OP_MUL, OP_DIV: begin
          op_mul  <= (i_op == OP_MUL);
          work_hi <= '0;
          work_lo <= i_a;
          opnd_b  <= i_b;
          count   <= CW'(W);
          o_dz    <= (i_op == OP_DIV) && (i_b == '0);
        end
        OP_SHR1C: begin
          o_result    <= {o_carry, i_a[W-1:1]};
          o_result_hi <= '0;
          o_carry     <= i_a[0];
        end
        OP_CLRC: begin
          o_result    <= '0;
          o_result_hi <= '0;
          o_carry     <= 1'b0;
        end
        OP_SETC: begin
          o_result    <= '0;
          o_result_hi <= '0;
          o_carry     <= 1'b1;
        end
        default: begin
          o_result    <= '0;
          o_result_hi <= '0;
          o_err       <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lc4_seq_alu.sv
// Directed bench for lc4_seq_alu: carry chains, MUL/DIV latency and values,
// divide-by-zero, reserved opcode, abort, ignored requests, and W=8/32 instances.
module tb_lc4_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        v16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, done16, c16, dz16, err16;
  logic [15:0] r16, rh16;
  logic [1:0]  st16;

  // 8-bit instance
  logic        v8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, done8, c8, dz8, err8;
  logic [7:0]  r8, rh8;
  logic [1:0]  st8;

  // 32-bit instance
  logic        v32 = 1'b0;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, done32, c32, dz32, err32;
  logic [31:0] r32, rh32;
  logic [1:0]  st32;

  lc4_seq_alu #(.WORD_SIZE(16)) dut16 (
    .clk(clk), .rst(rst), .i_valid(v16), .i_op(op16), .i_a(a16), .i_b(b16),
    .o_ready(rdy16), .o_done(done16), .o_result(r16), .o_result_hi(rh16),
    .o_carry(c16), .o_dz(dz16), .o_err(err16), .dbg_state(st16));

  lc4_seq_alu #(.WORD_SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .i_valid(v8), .i_op(op8), .i_a(a8), .i_b(b8),
    .o_ready(rdy8), .o_done(done8), .o_result(r8), .o_result_hi(rh8),
    .o_carry(c8), .o_dz(dz8), .o_err(err8), .dbg_state(st8));

  lc4_seq_alu #(.WORD_SIZE(32)) dut32 (
    .clk(clk), .rst(rst), .i_valid(v32), .i_op(op32), .i_a(a32), .i_b(b32),
    .o_ready(rdy32), .o_done(done32), .o_result(r32), .o_result_hi(rh32),
    .o_carry(c32), .o_dz(dz32), .o_err(err32), .dbg_state(st32));

  localparam logic [2:0] ADDC = 3'd0, SUBB = 3'd1, MUL = 3'd2, DIV = 3'd3;
  localparam logic [2:0] SHR1C = 3'd4, CLRC = 3'd5, SETC = 3'd6, RSVD = 3'd7;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at the current cycle (inputs already away from the edge),
  // then scramble the inputs and wait for o_done. lat counts cycles after T.
  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int rdy_low);
    v16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    v16 = 1'b0; op16 = 3'($urandom_range(0, 7)); a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1; rdy_low = 0;
    while (!done16 && lat < 100) begin
      if (!rdy16) rdy_low++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    v8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    v32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk); #1;
    v32 = 1'b0; a32 = $urandom; b32 = $urandom;
    lat = 1;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, rl, seen;

    // reset
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_ready", rdy16, 1);
    check("rst_done", done16, 0);
    check("rst_result", {rh16, r16}, 0);
    check("rst_flags", {c16, dz16, err16}, 0);
    check("rst_state", st16, 0);

    // ADDC carry chain, back-to-back from DONE
    issue16(CLRC, 16'h0000, 16'h0000, lat, rl);
    check("clrc_lat", lat, 1);
    check("clrc_carry", c16, 0);
    issue16(ADDC, 16'hFFFF, 16'h0001, lat, rl);
    check("addc1_lat", lat, 1);
    check("addc1_res", r16, 16'h0000);
    check("addc1_carry", c16, 1);
    issue16(ADDC, 16'h0000, 16'h0000, lat, rl);
    check("addc2_res", r16, 16'h0001);
    check("addc2_carry", c16, 0);
    check("addc2_hi", rh16, 0);

    // MUL
    issue16(MUL, 16'h1234, 16'h5678, lat, rl);
    check("mul1_lat", lat, 17);
    check("mul1_rdy_low", rl, 16);
    check("mul1_prod", {rh16, r16}, 32'h0626_0060);
    check("mul1_carry", c16, 0);
    issue16(MUL, 16'hFFFF, 16'hFFFF, lat, rl);
    check("mul2_prod", {rh16, r16}, 32'hFFFE_0001);

    // DIV and divide by zero
    issue16(DIV, 16'hFFFF, 16'h0007, lat, rl);
    check("div1_lat", lat, 17);
    check("div1_qr", {rh16, r16}, 32'h0001_2492);
    check("div1_dz", dz16, 0);
    issue16(DIV, 16'h1234, 16'h0000, lat, rl);
    check("divz_qr", {rh16, r16}, 32'h1234_FFFF);
    check("divz_dz", dz16, 1);
    issue16(ADDC, 16'h0001, 16'h0001, lat, rl);
    check("divz_clear_dz", dz16, 0);
    check("addc3_res", {rh16, r16}, 32'h0000_0002);

    // SHR1C / SUBB
    issue16(SETC, 16'h1111, 16'h2222, lat, rl);
    check("setc_carry_res", {c16, rh16, r16}, {1'b1, 32'h0});
    issue16(SHR1C, 16'h0003, 16'h0000, lat, rl);
    check("shr_res", r16, 16'h8001);
    check("shr_carry", c16, 1);
    issue16(SUBB, 16'h0005, 16'h0003, lat, rl);
    check("subb1_res", r16, 16'h0001);
    check("subb1_carry", c16, 0);
    issue16(SUBB, 16'h0000, 16'h0001, lat, rl);
    check("subb2_res", r16, 16'hFFFF);
    check("subb2_carry", c16, 1);

    // reserved opcode leaves carry alone
    issue16(RSVD, 16'h1111, 16'h2222, lat, rl);
    check("rsvd_res", {rh16, r16}, 0);
    check("rsvd_err", err16, 1);
    check("rsvd_carry", c16, 1);
    issue16(SETC, 16'h0000, 16'h0000, lat, rl);
    check("err_clear", err16, 0);

    // abort a MUL with rst in cycle T+5
    v16 = 1'b1; op16 = MUL; a16 = 16'h1234; b16 = 16'h5678;
    @(posedge clk); #1;
    v16 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_busy", rdy16, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", rdy16, 1);
    check("abort_done", done16, 0);
    check("abort_carry", c16, 0);
    check("abort_state", st16, 0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done16) seen++; end
    check("abort_no_done", seen, 0);

    // request during BUSY is ignored
    v16 = 1'b1; op16 = DIV; a16 = 16'hFFFF; b16 = 16'h0007;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    v16 = 1'b1; op16 = ADDC; a16 = 16'h0001; b16 = 16'h0001;
    @(posedge clk); #1;
    v16 = 1'b0; lat++;
    while (!done16 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("ign_lat", lat, 17);
    check("ign_qr", {rh16, r16}, 32'h0001_2492);
    check("ign_carry", c16, 0);
    @(posedge clk); #1;
    check("ign_no_extra_done", {done16, rdy16}, 2'b01);

    // WORD_SIZE = 8
    issue8(MUL, 8'hFF, 8'hFF, lat);
    check("w8_mul_lat", lat, 9);
    check("w8_mul", {rh8, r8}, 16'hFE01);
    issue8(DIV, 8'hFF, 8'h07, lat);
    check("w8_div", {rh8, r8}, 16'h0324);
    issue8(ADDC, 8'hFF, 8'h01, lat);
    check("w8_addc", {c8, r8}, 9'h100);

    // WORD_SIZE = 32
    issue32(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("w32_mul_lat", lat, 33);
    check("w32_mul", {rh32, r32}, 64'hFFFF_FFFE_0000_0001);
    issue32(DIV, 32'hFFFF_FFFF, 32'h0000_0007, lat);
    check("w32_div", {rh32, r32}, 64'h0000_0003_2492_4924);
    issue32(DIV, 32'h1234_5678, 32'h0, lat);
    check("w32_divz", {dz32, rh32, r32}, {1'b1, 64'h1234_5678_FFFF_FFFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
